// File: rtl/me_scheduler.sv
// SHA-256 message schedule sequencer: loads 16 words, streams W_0..W_63 to MC, then republishes MC's 8 hash words as a digest stream.
// Latency: W_0 appears the cycle after M_15 is accepted; the digest follows 64 cycles later at one word per cycle, valid one cycle after each OUTPUT cycle.
// Backpressure: msg_ready_out is high only in IDLE/LOAD and decodes from state alone; there is no stall downstream. ME_BSWAP_EN byte-reverses input words.
module me_scheduler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] msg_in,
  input  logic                  msg_valid_in,
  output logic                  msg_ready_out,
  input  logic [DATA_WIDTH-1:0] hash_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            FSM_core_out,
  output logic [6:0]            core_count_out,
  output logic [DATA_WIDTH-1:0] digest_out,
  output logic [2:0]            digest_idx_out,
  output logic                  digest_dv_out,
  output logic                  busy_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    LOAD    = 3'b001,
    COMPUTE = 3'b011,
    OUTPUT  = 3'b100
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            load_cnt;
  logic [DATA_WIDTH-1:0] win [16];
  logic [DATA_WIDTH-1:0] word_in;
  logic [DATA_WIDTH-1:0] w_new;
  logic                  accept;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

`ifdef ME_BSWAP_EN
  assign word_in = {msg_in[7:0], msg_in[15:8], msg_in[23:16], msg_in[31:24]};
`else
  assign word_in = msg_in;
`endif

  assign msg_ready_out = (state == IDLE) || (state == LOAD);
  assign accept        = msg_valid_in && msg_ready_out;
  assign FSM_core_out  = state;
  // win[i] holds W_{t+i}, so the next word needs taps 14, 9, 1 and 0
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    if (accept && load_cnt == 4'd15) state_nxt = COMPUTE;
      COMPUTE: if (core_count_out == 7'd63) state_nxt = OUTPUT;
      OUTPUT:  if (core_count_out == 7'd7) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      load_cnt       <= '0;
      core_count_out <= '0;
      data_out       <= '0;
      digest_out     <= '0;
      digest_idx_out <= '0;
      digest_dv_out  <= 1'b0;
      busy_out       <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15]  <= word_in;
        load_cnt <= (state == IDLE) ? 4'd1 : load_cnt + 4'd1;
      end else if (state == COMPUTE) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_new;
      end

      if (state_nxt != state)
        core_count_out <= '0;
      else if (state == COMPUTE || state == OUTPUT)
        core_count_out <= core_count_out + 7'd1;
      else
        core_count_out <= '0;

      // win[1] becomes win[0] on this edge, so it is the next W_t
      data_out <= (state_nxt == COMPUTE) ? win[1] : '0;
      busy_out <= (state_nxt == COMPUTE) || (state_nxt == OUTPUT);

      if (state == OUTPUT) begin
        digest_out     <= hash_in;
        digest_idx_out <= core_count_out[2:0];
        digest_dv_out  <= 1'b1;
      end else begin
        digest_dv_out  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/me_scheduler.md
# me_scheduler

Message-expansion scheduler and sequencer that drives the SHA-256 compression core (MC). It accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready interface. It then emits the 64 expanded schedule words W_0..W_63, one per clock, together with the core state code and round count MC consumes. Afterwards it walks MC's eight hash-word outputs and re-publishes them as a registered digest stream.

## Interface
- DATA_WIDTH, 32, word width; only 32 is supported.
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- msg_in  input  DATA_WIDTH  message word, word 0 first.
- msg_valid_in  input  1  msg_in holds a valid word.
- msg_ready_out  output  1  scheduler accepts a word this cycle.
- hash_in  input  DATA_WIDTH  MC data_out, combinational from core_count_out.
- data_out  output  DATA_WIDTH  W_t to MC data_in.
- FSM_core_out  output  3  state code to MC FSM_core_in.
- core_count_out  output  7  round / word index to MC core_count_in.
- digest_out  output  DATA_WIDTH  registered hash word.
- digest_idx_out  output  3  index of digest_out, 0..7.
- digest_dv_out  output  1  digest_out valid, one cycle per word.
- busy_out  output  1  high in COMPUTE and OUTPUT.

## Operation
- States and FSM_core_out codes: IDLE = 3'b000, LOAD = 3'b001, COMPUTE = 3'b011, OUTPUT = 3'b100. FSM_core_out always equals the state code.
- msg_ready_out = 1 in IDLE and LOAD, 0 otherwise. A word is accepted on a rising edge where msg_valid_in & msg_ready_out.
- IDLE: the first accepted word is stored as M_0 and the FSM moves to LOAD with load count = 1.
- LOAD: accepts M_1..M_15. Gaps in msg_valid_in stall without loss. The edge that accepts M_15 moves the FSM to COMPUTE with t = 0.
- COMPUTE: lasts exactly 64 cycles, t = 0..63, core_count_out = t.
  - data_out = W_t, where W_t = M_t for t < 16.
  - For t ≥ 16, W_t = σ1(W_{t-2}) + W_{t-7} + σ0(W_{t-15}) + W_{t-16}, mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Storage is a 16-word sliding window, shifted once per COMPUTE cycle. A full 64-entry array is not allowed.
- After t = 63 the FSM moves to OUTPUT with core_count_out = 0.
- OUTPUT: lasts exactly 8 cycles with core_count_out = k, k = 0..7.
  - On each edge, digest_out <= hash_in and digest_idx_out <= k; digest_dv_out is high the following cycle.
  - After k = 7 the FSM returns to IDLE.
- Outside COMPUTE, data_out = 0. In IDLE and LOAD, core_count_out = 0.
- busy_out = 1 in COMPUTE and OUTPUT.
- msg_valid_in during COMPUTE or OUTPUT is ignored, because ready = 0.

## Timing
- Reset values:
  - State IDLE; msg_ready_out = 1.
  - FSM_core_out = 3'b000, core_count_out = 0, data_out = 0.
  - digest_out = 0, digest_idx_out = 0, digest_dv_out = 0, busy_out = 0.
  - Window and load count cleared.
- All outputs except msg_ready_out are registered. msg_ready_out is decoded from the state register only, never from msg_valid_in.
- Latency: the cycle after M_15 is accepted presents FSM_core_out = 011, core_count_out = 0, data_out = M_0.
- Throughput: 16 load cycles minimum, plus 64 COMPUTE cycles, plus 8 OUTPUT cycles.
- digest_dv_out pulses 8 times on consecutive cycles, starting one cycle after the first OUTPUT cycle. The last pulse coincides with the first IDLE cycle.
- IDLE accepts a new M_0 on its first cycle, back-to-back with the final digest pulse.
- Reset mid-operation, in any state: return immediately to reset values. The partial block or expansion is discarded.

## Configuration
- ME_BSWAP_EN
  - Defined: every accepted msg_in is byte-reversed before storage ({b0,b1,b2,b3} -> {b3,b2,b1,b0}), for little-endian sources. digest_out is not swapped.
  - Undefined: words are stored as received.

## Test plan
- Reset, then check all outputs at their reset values and msg_ready_out = 1. Assert rst_n low again mid-COMPUTE (t = 30) -> FSM_core_out = 000 and data_out = 0 immediately; the next block runs normally.
- "abc" padded block (0x61626380, 14 × 0x00000000, 0x00000018), fed back-to-back -> COMPUTE starts the cycle after the 16th word.
  - data_out at t = 0 is 0x61626380 and at t = 15 is 0x00000018.
  - W_16 = 0x61626380, W_17 = 0x000F0000, W_18 = 0x7DA86405.
  - W_0..W_63 match the C model's expected_W.
- Same block with msg_valid_in deasserted for 3 cycles after words 4 and 11 -> identical W stream; msg_ready_out stays 1 throughout LOAD.
- OUTPUT phase with the bench driving hash_in = H[core_count_out], using the "abc" digest (0xBA7816BF .. 0xF20015AD).
  - Exactly 8 digest_dv_out pulses with idx 0..7 and matching values.
  - busy_out falls on return to IDLE.
- Words presented during COMPUTE -> not accepted, W stream unchanged. A second block driven immediately after the final digest pulse -> processed correctly.
- With ME_BSWAP_EN defined, feed 0x80636261 as word 0 -> data_out at t = 0 is 0x61626380; the rest as in the "abc" case.
